// File: rtl/fb_arb_pkg.sv
// rtl/fb_arb_pkg.sv - shared types and defaults for the framebuffer write arbiter
// Purpose: arbiter state encoding and the framebuffer geometry defaults that
//          are shared with the framebuffer controller.
package fb_arb_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_ACK    = 2'd3
    } arb_state_e;

    localparam int FB_PIXELS_DEF = 640 * 480;
    localparam int ADDR_W_DEF    = 19;
    localparam int COLOR_W_DEF   = 4;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker
// Purpose: picks the first eligible requester searching ptr+1, ptr+2, ...
//          modulo N.
// Ports:
//   eligible_i  requesters that may be granted
//   ptr_i       index granted last; it has lowest priority this cycle
//   grant_o     one-hot grant (all zero when nothing is eligible)
//   idx_o       index of the granted requester (0 when none)
//   any_o       a grant was issued
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     eligible_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any_o && eligible_i[(int'(ptr_i) + k) % N]) begin
                any_o                              = 1'b1;
                grant_o[(int'(ptr_i) + k) % N]     = 1'b1;
                idx_o                              = IDX_W'((int'(ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - round-robin arbiter for the framebuffer pixel-write port
// Purpose: shares one registered pixel-write port between NREQ drawing
//          requesters, gathers per-requester frame ends, then drains, holds
//          done for DONE_CYCLES and acknowledges the frame.
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   req_valid/addr/color        per-requester pixel writes (packed by index)
//   req_frame_end               per-requester last-pixel pulse
//   req_ready                   one-hot combinational grant
//   frame_ack                   1-cycle frame committed pulse
//   w_addr/color_in/en_w        registered framebuffer write port
//   done                        registered frame-complete level
//   busy_commit                 high in DRAIN, COMMIT, ACK
//   drop_count                  saturating out-of-range write count
//   frame_count                 committed frame count (wraps)
module fb_write_arbiter
    import fb_arb_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int COLOR_W     = COLOR_W_DEF,
    parameter int FB_PIXELS   = FB_PIXELS_DEF,
    parameter int DONE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*ADDR_W-1:0]  req_addr,
    input  logic [NREQ*COLOR_W-1:0] req_color,
    input  logic [NREQ-1:0]         req_frame_end,
    output logic [NREQ-1:0]         req_ready,
    output logic                    frame_ack,
    output logic [ADDR_W-1:0]       w_addr,
    output logic [COLOR_W-1:0]      color_in,
    output logic                    en_w,
    output logic                    done,
    output logic                    busy_commit,
    output logic [15:0]             drop_count,
    output logic [15:0]             frame_count
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(DONE_CYCLES + 1);
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(FB_PIXELS);

    arb_state_e          state_q;
    logic [NREQ-1:0]     end_seen_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [ADDR_W-1:0]   w_addr_q;
    logic [COLOR_W-1:0]  color_q;
    logic                en_w_q;
    logic                done_q;
    logic                frame_ack_q;
    logic [15:0]         frame_cnt_q;
    logic [15:0]         drop_q, drop_d;
    logic [CNT_W-1:0]    done_cnt_q;

    logic [NREQ-1:0]     eligible;
    logic [NREQ-1:0]     grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_any;
    logic [ADDR_W-1:0]   sel_addr;
    logic [COLOR_W-1:0]  sel_color;
    logic                in_range;
    logic [NREQ-1:0]     end_seen_nxt;

    // Only RUN grants; a requester that has ended its frame sits out until ACK.
    assign eligible = (state_q == ST_RUN) ? (req_valid & ~end_seen_q) : '0;

    rr_pick #(.N(NREQ), .IDX_W(IDX_W)) u_pick (
        .eligible_i (eligible),
        .ptr_i      (rr_ptr_q),
        .grant_o    (grant),
        .idx_o      (grant_idx),
        .any_o      (grant_any)
    );

    // The grant only covers eligible (hence valid) requesters, so any grant is a transfer.
    assign sel_addr     = req_addr[int'(grant_idx) * ADDR_W +: ADDR_W];
    assign sel_color    = req_color[int'(grant_idx) * COLOR_W +: COLOR_W];
    assign in_range     = {1'b0, sel_addr} < ADDR_LIMIT;
    assign end_seen_nxt = end_seen_q | req_frame_end;

    always_comb begin
        drop_d = drop_q;
        if (grant_any && !in_range && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // Written every cycle so the counter always follows drop_d.
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            end_seen_q  <= '0;
            rr_ptr_q    <= IDX_W'(NREQ - 1);
            w_addr_q    <= '0;
            color_q     <= '0;
            en_w_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_ack_q <= 1'b0;
            frame_cnt_q <= '0;
            done_cnt_q  <= '0;
        end else begin
            en_w_q      <= 1'b0;
            frame_ack_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (grant_any) begin
                        rr_ptr_q <= grant_idx;
                        w_addr_q <= sel_addr;
                        color_q  <= sel_color;
                        en_w_q   <= in_range;
                    end
                    end_seen_q <= end_seen_nxt;
                    if (&end_seen_nxt) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state_q    <= ST_COMMIT;
                    done_q     <= 1'b1;
                    done_cnt_q <= CNT_W'(DONE_CYCLES - 1);
                end
                ST_COMMIT: begin
                    if (done_cnt_q == '0) begin
                        state_q     <= ST_ACK;
                        done_q      <= 1'b0;
                        frame_ack_q <= 1'b1;
                        end_seen_q  <= '0;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end else begin
                        done_cnt_q <= done_cnt_q - 1'b1;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign req_ready   = grant;
    assign frame_ack   = frame_ack_q;
    assign w_addr      = w_addr_q;
    assign color_in    = color_q;
    assign en_w        = en_w_q;
    assign done        = done_q;
    assign busy_commit = (state_q != ST_RUN);
    assign drop_count  = drop_q;
    assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - self-checking bench for fb_write_arbiter
module tb_fb_write_arbiter;

    localparam int NREQ        = 3;
    localparam int ADDR_W      = 19;
    localparam int COLOR_W     = 4;
    localparam int FB_PIXELS   = 307200;
    localparam int DONE_CYCLES = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*ADDR_W-1:0]  req_addr;
    logic [NREQ*COLOR_W-1:0] req_color;
    logic [NREQ-1:0]         req_frame_end;
    logic [NREQ-1:0]         req_ready;
    logic                    frame_ack;
    logic [ADDR_W-1:0]       w_addr;
    logic [COLOR_W-1:0]      color_in;
    logic                    en_w;
    logic                    done;
    logic                    busy_commit;
    logic [15:0]             drop_count;
    logic [15:0]             frame_count;

    always #5 clk = ~clk;

    fb_write_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W),
        .FB_PIXELS(FB_PIXELS), .DONE_CYCLES(DONE_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_color(req_color),
        .req_frame_end(req_frame_end), .req_ready(req_ready),
        .frame_ack(frame_ack), .w_addr(w_addr), .color_in(color_in),
        .en_w(en_w), .done(done), .busy_commit(busy_commit),
        .drop_count(drop_count), .frame_count(frame_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stimulus for the current cycle
    bit s_rst;
    bit s_valid [NREQ];
    int s_addr  [NREQ];
    int s_color [NREQ];
    bit s_fe    [NREQ];

    // Reference model: phase 0=RUN 1=DRAIN 2=COMMIT 3=ACK
    int m_phase, m_ptr, m_waddr, m_color, m_drop, m_frames, m_left;
    bit m_end [NREQ];
    bit m_en, m_done, m_ack;
    bit chk_en;

    function automatic void model_reset();
        m_phase = 0; m_ptr = NREQ - 1; m_waddr = 0; m_color = 0;
        m_drop = 0; m_frames = 0; m_left = 0;
        m_en = 0; m_done = 0; m_ack = 0;
        for (int i = 0; i < NREQ; i++) m_end[i] = 0;
    endfunction

    function automatic int exp_grant();
        if (m_phase != 0) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (s_valid[i] && !m_end[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_step();
        int g;
        bit all_end;
        g = exp_grant();
        if (!s_rst) begin
            model_reset();
            return;
        end
        m_ack = 0;
        m_en  = 0;
        case (m_phase)
            0: begin
                if (g >= 0) begin
                    m_ptr   = g;
                    m_waddr = s_addr[g];
                    m_color = s_color[g];
                    if (s_addr[g] < FB_PIXELS) m_en = 1;
                    else if (m_drop < 65535) m_drop++;
                end
                all_end = 1;
                for (int i = 0; i < NREQ; i++) begin
                    if (s_fe[i]) m_end[i] = 1;
                    if (!m_end[i]) all_end = 0;
                end
                if (all_end) m_phase = 1;
            end
            1: begin
                m_phase = 2; m_done = 1; m_left = DONE_CYCLES;
            end
            2: begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = 3; m_done = 0; m_ack = 1;
                    m_frames = (m_frames + 1) % 65536;
                    for (int i = 0; i < NREQ; i++) m_end[i] = 0;
                end
            end
            default: m_phase = 0;
        endcase
    endfunction

    task automatic cycle();
        int g;
        @(negedge clk);
        rst = s_rst;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]                      = s_valid[i];
            req_addr[i*ADDR_W +: ADDR_W]      = ADDR_W'(s_addr[i]);
            req_color[i*COLOR_W +: COLOR_W]   = COLOR_W'(s_color[i]);
            req_frame_end[i]                  = s_fe[i];
        end
        #1;
        if (chk_en) begin
            g = exp_grant();
            check("req_ready",   32'(req_ready),  (g < 0) ? 32'd0 : (32'd1 << g));
            check("en_w",        32'(en_w),       32'(m_en));
            check("w_addr",      32'(w_addr),     32'(m_waddr));
            check("color_in",    32'(color_in),   32'(m_color));
            check("done",        32'(done),       32'(m_done));
            check("frame_ack",   32'(frame_ack),  32'(m_ack));
            check("busy_commit", 32'(busy_commit), 32'(m_phase != 0));
            check("drop_count",  32'(drop_count), 32'(m_drop));
            check("frame_count", 32'(frame_count), 32'(m_frames));
        end
        model_step();
    endtask

    task automatic idle();
        s_rst = 1;
        for (int i = 0; i < NREQ; i++) begin
            s_valid[i] = 0; s_addr[i] = 0; s_color[i] = 0; s_fe[i] = 0;
        end
    endtask

    task automatic all_end_pulse();
        for (int i = 0; i < NREQ; i++) s_fe[i] = 1;
        cycle();
        for (int i = 0; i < NREQ; i++) s_fe[i] = 0;
    endtask

    // Runs until the model is back in RUN, counting done-high cycles seen on the DUT.
    task automatic run_to_idle(output int done_seen, output int ack_seen);
        int n;
        done_seen = 0; ack_seen = 0; n = 0;
        while (m_phase != 0 && n < 40) begin
            cycle();
            if (done) done_seen++;
            if (frame_ack) ack_seen++;
            n++;
        end
        if (n >= 40) check("phase_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int dn, ak, nb;
        model_reset();
        idle();
        chk_en = 0;
        s_rst = 0;
        cycle();
        chk_en = 1;
        cycle();
        s_rst = 1;
        cycle();

        // Round robin between two continuously valid requesters
        s_valid[0] = 1; s_addr[0] = 10; s_color[0] = 1;
        s_valid[1] = 1; s_addr[1] = 20; s_color[1] = 2;
        repeat (6) cycle();

        // Single requester
        idle();
        s_valid[1] = 1; s_addr[1] = 5; s_color[1] = 4'hA;
        repeat (3) cycle();

        // Out-of-range and the last in-range address
        idle();
        s_valid[0] = 1; s_addr[0] = FB_PIXELS; s_color[0] = 3;
        repeat (2) cycle();
        s_addr[0] = FB_PIXELS - 1;
        cycle();
        idle();
        cycle();

        // Saturation of the drop counter
        force dut.drop_q = 16'hFFFF;
        m_drop = 65535;
        cycle();
        release dut.drop_q;
        s_valid[2] = 1; s_addr[2] = (1 << ADDR_W) - 1; s_color[2] = 5;
        repeat (3) cycle();
        idle();
        cycle();

        // Frame commit: req0 last pixel at 7, others end three cycles later
        s_valid[0] = 1; s_addr[0] = 7; s_color[0] = 6; s_fe[0] = 1;
        cycle();
        s_fe[0] = 0; s_addr[0] = 8;
        s_valid[1] = 1; s_addr[1] = 30; s_color[1] = 7;
        repeat (2) cycle();
        s_fe[1] = 1; s_fe[2] = 1;
        cycle();
        s_fe[1] = 0; s_fe[2] = 0;
        run_to_idle(dn, ak);
        check("commit_done_cycles", 32'(dn), 32'(DONE_CYCLES));
        check("commit_ack_pulses",  32'(ak), 32'd1);
        check("commit_frames", 32'(frame_count), 32'd1);
        repeat (3) cycle();

        // Late frame end during COMMIT is ignored
        idle();
        all_end_pulse();
        nb = 0;
        while (m_phase != 2 && nb < 10) begin cycle(); nb++; end
        s_fe[0] = 1;
        cycle();
        s_fe[0] = 0;
        run_to_idle(dn, ak);
        s_valid[0] = 1; s_addr[0] = 40;
        repeat (3) cycle();

        // Reset on the second done cycle aborts the commit
        idle();
        all_end_pulse();
        nb = 0;
        while (!(m_done && m_left == DONE_CYCLES - 1) && nb < 10) begin cycle(); nb++; end
        check("reached_commit", 32'(done), 32'd1);
        s_rst = 0;
        cycle();
        s_rst = 1;
        cycle();
        check("abort_done", 32'(done), 32'd0);
        check("abort_frames", 32'(frame_count), 32'd0);
        repeat (2) cycle();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            s_rst = ($urandom_range(0, 499) != 0);
            for (int i = 0; i < NREQ; i++) begin
                s_valid[i] = $urandom_range(0, 1);
                s_addr[i]  = ($urandom_range(0, 7) == 0) ? $urandom_range(FB_PIXELS, (1 << ADDR_W) - 1)
                                                         : $urandom_range(0, FB_PIXELS - 1);
                s_color[i] = $urandom_range(0, (1 << COLOR_W) - 1);
                s_fe[i]    = ($urandom_range(0, 39) == 0);
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Shares the framebuffer's single pixel-write port (w_addr / color_in / en_w) between NREQ drawing requesters, e.g. the vector line generator and the text/score overlay.
- Grants one write per cycle using round-robin arbitration.
- Collects a per-requester end-of-frame indication. Once every requester has finished, it drains, raises the framebuffer's `done` for a fixed window to trigger the buffer rotation, then acknowledges the frame to all requesters.

Parameters:
- NREQ, 2, number of requesters (2..8)
- ADDR_W, 19, framebuffer address width
- COLOR_W, 4, pixel colour width
- FB_PIXELS, 307200, number of valid addresses; addresses >= FB_PIXELS are dropped
- DONE_CYCLES, 4, cycles `done` is held high in COMMIT (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- req_valid  in  NREQ  requester i has a pixel write pending
- req_addr  in  NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_color  in  NREQ*COLOR_W  packed colours, same packing
- req_frame_end  in  NREQ  1-cycle pulse: requester i has issued its last pixel of the frame
- req_ready  out  NREQ  one-hot grant; a write transfers when req_valid[i] & req_ready[i]
- frame_ack  out  1  1-cycle pulse: frame committed, requesters may start the next frame
- w_addr  out  ADDR_W  framebuffer write address
- color_in  out  COLOR_W  framebuffer write colour
- en_w  out  1  framebuffer write enable
- done  out  1  frame-complete level to the framebuffer (rising edge consumed there)
- busy_commit  out  1  high in DRAIN, COMMIT, ACK
- drop_count  out  16  saturating count of out-of-range writes
- frame_count  out  16  committed frames, wraps at 2^16

Behaviour:
- Reset (sampled on clk rising while rst==0): every output 0, state=RUN, end_seen=0, rr_ptr=NREQ-1 (so requester 0 has first priority), drop_count=0, frame_count=0. A reset in any state aborts it; `done` is low on the cycle after reset.
- The state machine has four states: RUN, DRAIN, COMMIT, ACK.
- RUN, eligibility: requester i is eligible when req_valid[i] & ~end_seen[i].
- RUN, grant: req_ready is combinational and one-hot. It goes to the first eligible requester searching rr_ptr+1, rr_ptr+2, ... modulo NREQ. rr_ptr updates to the granted index only on a transfer.
- RUN, write port: w_addr, color_in and en_w are registered, so there is 1-cycle latency from transfer to en_w. en_w=1 only if the transferred address < FB_PIXELS. Otherwise en_w=0 and drop_count increments, saturating at 16'hFFFF.
- RUN, no eligible requester: en_w=0 on the next cycle.
- RUN, frame end: req_frame_end[i] sets end_seen[i]. If asserted together with a transfer from i, that pixel is accepted as the frame's last. Once end_seen[i] is set, req_ready[i]=0 until ACK.
- RUN, exit: when all end_seen bits are set (counting bits set this cycle), go to DRAIN next cycle.
- DRAIN: 1 cycle, all req_ready=0, so the final registered write is presented on en_w. Then go to COMMIT.
- COMMIT: done=1 for exactly DRAIN_CYCLES... specifically DONE_CYCLES consecutive cycles, tracked by a down-counter. en_w=0 and req_ready=0 throughout. Then go to ACK.
- ACK: 1 cycle. done=0, frame_ack=1, end_seen cleared, frame_count+1. Then go to RUN.
- Duplicate or out-of-window frame-end pulses:
  - A req_frame_end on an already-set end_seen bit is ignored.
  - A req_frame_end pulse during DRAIN, COMMIT or ACK is ignored; requesters must wait for frame_ack.
- `done` is driven from a flop, never combinationally. There are at least 2 cycles of done=0 between commits (ACK plus the first RUN cycle), so the framebuffer always sees a fresh rising edge.
- Rotation guard: if the framebuffer has not finished clearing, it ignores the edge. The arbiter does not retry; the frame is simply not rotated.

Decomposition:
- Package fb_arb_pkg holds:
  - the state enum (RUN, DRAIN, COMMIT, ACK, 2 bits)
  - the FB_PIXELS default constant (640*480)
  - the ADDR_W/COLOR_W defaults shared with the framebuffer controller
- Sub-module rr_pick holds the purely combinational round-robin priority picker. Inputs: eligible vector and rr_ptr. Outputs: one-hot grant and index. It is separately testable.

Test Plan:
- Round-robin: NREQ=2, both valid continuously with addrs 10 and 20. Grants alternate 0,1,0,1 starting with 0. en_w is high every cycle from cycle 1. w_addr sequence is 10,20,10,20.
- Single requester: only req1 valid with addr 5, colour 4'hA. req_ready=2'b10. One cycle later w_addr=5, color_in=4'hA, en_w=1. rr_ptr=1.
- Out-of-range: a transfer at addr 307200 gets ready=1. Next cycle en_w=0 and drop_count=1. With drop_count forced to FFFF, a further drop leaves it at FFFF.
- Frame commit: req0 pulses frame_end with a last pixel at addr 7. req1 pulses 3 cycles later. Required sequence:
  - req0 is never granted after its pulse
  - DRAIN, then done=1 for exactly 4 cycles
  - frame_ack pulse on the following cycle, frame_count=1, both requesters eligible again
- Late pulse: req0 frame_end during COMMIT. It is ignored, and end_seen=0 after ACK.
- Reset in COMMIT: rst=0 on the 2nd done cycle. Next cycle done=0, state=RUN, frame_count=0, no frame_ack pulse.
